// File: rtl/hazard_forward_ctrl.sv
// ID-stage hazard controller: per-port forwarding selects, NOP injection, PC/IF-ID holds.
// Optional HAZARD_STATS_EN adds saturating stall/forward event counters.
module hazard_forward_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_RS,
    input  logic [4:0] ID_RT,
    input  logic       ID_USES_RS,
    input  logic       ID_USES_RT,
    input  logic       ID_EARLY_USE,
    input  logic [4:0] EX_DEST,
    input  logic [4:0] MEM_DEST,
    input  logic [4:0] WB_DEST,
    input  logic       EX_RF_ENABLE,
    input  logic       MEM_RF_ENABLE,
    input  logic       WB_RF_ENABLE,
    input  logic       EX_LOAD_INSTR,
    input  logic       MEM_LOAD_INSTR,
    output logic [1:0] FWD_SEL_PA,
    output logic [1:0] FWD_SEL_PB,
    output logic       CONTROL_MUX,
    output logic       PC_LE,
    output logic       IF_ID_LE
`ifdef HAZARD_STATS_EN
    ,
    input  logic        STATS_CLEAR,
    output logic [31:0] STALL_COUNT,
    output logic [31:0] FWD_COUNT
`endif
);

    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [4:0] src_addr [2];
    logic       src_used [2];
    logic [1:0] fwd_sel  [2];
    logic [1:0] ex_match;
    logic       load_hazard;

    // BR_WAIT already implies the MEM instruction is the load; the flag is informational only.
    logic unused_mem_load;
    assign unused_mem_load = MEM_LOAD_INSTR;

    assign src_addr[0] = ID_RS;
    assign src_addr[1] = ID_RT;
    assign src_used[0] = ID_USES_RS;
    assign src_used[1] = ID_USES_RT;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic ex_hit, mem_hit, wb_hit;
            assign ex_hit  = EX_RF_ENABLE  && (EX_DEST  != 5'd0) && (EX_DEST  == src_addr[gi]) && src_used[gi];
            assign mem_hit = MEM_RF_ENABLE && (MEM_DEST != 5'd0) && (MEM_DEST == src_addr[gi]) && src_used[gi];
            assign wb_hit  = WB_RF_ENABLE  && (WB_DEST  != 5'd0) && (WB_DEST  == src_addr[gi]) && src_used[gi];
            assign ex_match[gi] = ex_hit;

            // Youngest producer wins.
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (ex_hit)
                    fwd_sel[gi] = 2'b01;
                else if (mem_hit)
                    fwd_sel[gi] = 2'b10;
                else if (wb_hit)
                    fwd_sel[gi] = 2'b11;
            end
        end
    endgenerate

    assign FWD_SEL_PA  = fwd_sel[0];
    assign FWD_SEL_PB  = fwd_sel[1];
    assign load_hazard = EX_LOAD_INSTR && (|ex_match);

    always_comb begin
        state_d     = state_q;
        CONTROL_MUX = 1'b0;
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        case (state_q)
            RUN: begin
                if (load_hazard) begin
                    CONTROL_MUX = 1'b1;
                    PC_LE       = 1'b0;
                    IF_ID_LE    = 1'b0;
                    if (ID_EARLY_USE)
                        state_d = BR_WAIT;
                end
            end
            BR_WAIT: begin
                // Load sits in MEM; its data reaches ID only once it is in WB.
                CONTROL_MUX = 1'b1;
                PC_LE       = 1'b0;
                IF_ID_LE    = 1'b0;
                state_d     = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] fwd_count_q, fwd_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        fwd_count_d   = fwd_count_q;
        if (STATS_CLEAR) begin
            stall_count_d = 32'd0;
            fwd_count_d   = 32'd0;
        end else begin
            if (CONTROL_MUX && !(&stall_count_q))
                stall_count_d = stall_count_q + 32'd1;
            if (((FWD_SEL_PA != 2'b00) || (FWD_SEL_PB != 2'b00)) && !(&fwd_count_q))
                fwd_count_d = fwd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
            fwd_count_q   <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign STALL_COUNT = stall_count_q;
    assign FWD_COUNT   = fwd_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed + random bench for hazard_forward_ctrl against a stall-budget reference model.
// Define HAZARD_STATS_EN to also check the event counters.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_RS, ID_RT;
    logic       ID_USES_RS, ID_USES_RT, ID_EARLY_USE;
    logic [4:0] EX_DEST, MEM_DEST, WB_DEST;
    logic       EX_RF_ENABLE, MEM_RF_ENABLE, WB_RF_ENABLE;
    logic       EX_LOAD_INSTR, MEM_LOAD_INSTR;
    logic [1:0] FWD_SEL_PA, FWD_SEL_PB;
    logic       CONTROL_MUX, PC_LE, IF_ID_LE;
`ifdef HAZARD_STATS_EN
    logic        STATS_CLEAR;
    logic [31:0] STALL_COUNT, FWD_COUNT;
`endif

    int checks = 0;
    int errors = 0;
    // Extra stall cycles still owed by an early-use consumer after its first stall.
    int pend = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_fwd   = 32'd0;

    always #5 clk = ~clk;

    hazard_forward_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ID_RS         (ID_RS),
        .ID_RT         (ID_RT),
        .ID_USES_RS    (ID_USES_RS),
        .ID_USES_RT    (ID_USES_RT),
        .ID_EARLY_USE  (ID_EARLY_USE),
        .EX_DEST       (EX_DEST),
        .MEM_DEST      (MEM_DEST),
        .WB_DEST       (WB_DEST),
        .EX_RF_ENABLE  (EX_RF_ENABLE),
        .MEM_RF_ENABLE (MEM_RF_ENABLE),
        .WB_RF_ENABLE  (WB_RF_ENABLE),
        .EX_LOAD_INSTR (EX_LOAD_INSTR),
        .MEM_LOAD_INSTR(MEM_LOAD_INSTR),
        .FWD_SEL_PA    (FWD_SEL_PA),
        .FWD_SEL_PB    (FWD_SEL_PB),
        .CONTROL_MUX   (CONTROL_MUX),
        .PC_LE         (PC_LE),
        .IF_ID_LE      (IF_ID_LE)
`ifdef HAZARD_STATS_EN
        ,
        .STATS_CLEAR   (STATS_CLEAR),
        .STALL_COUNT   (STALL_COUNT),
        .FWD_COUNT     (FWD_COUNT)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_sel(input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return 2'b00;
        if (EX_RF_ENABLE  && EX_DEST  == src) return 2'b01;
        if (MEM_RF_ENABLE && MEM_DEST == src) return 2'b10;
        if (WB_RF_ENABLE  && WB_DEST  == src) return 2'b11;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        ID_RS = 0; ID_RT = 0; ID_USES_RS = 0; ID_USES_RT = 0; ID_EARLY_USE = 0;
        EX_DEST = 0; MEM_DEST = 0; WB_DEST = 0;
        EX_RF_ENABLE = 0; MEM_RF_ENABLE = 0; WB_RF_ENABLE = 0;
        EX_LOAD_INSTR = 0; MEM_LOAD_INSTR = 0;
`ifdef HAZARD_STATS_EN
        STATS_CLEAR = 0;
`endif
    endtask

    // Check outputs for the current inputs, then advance one clock and the model.
    task automatic cycle(input string tag);
        logic [1:0] ea, eb;
        logic       hz, st;
        #1;
        ea = ref_sel(ID_RS, ID_USES_RS);
        eb = ref_sel(ID_RT, ID_USES_RT);
        hz = EX_LOAD_INSTR && EX_RF_ENABLE && EX_DEST != 5'd0 &&
             ((ID_USES_RS && ID_RS == EX_DEST) || (ID_USES_RT && ID_RT == EX_DEST));
        st = (pend > 0) || hz;
        chk({tag, ".pa"}, 32'(FWD_SEL_PA), 32'(ea));
        chk({tag, ".pb"}, 32'(FWD_SEL_PB), 32'(eb));
        chk({tag, ".cmux"}, 32'(CONTROL_MUX), 32'(st));
        chk({tag, ".pc_le"}, 32'(PC_LE), 32'(!st));
        chk({tag, ".ifid_le"}, 32'(IF_ID_LE), 32'(!st));
`ifdef HAZARD_STATS_EN
        chk({tag, ".stall_cnt"}, STALL_COUNT, m_stall);
        chk({tag, ".fwd_cnt"}, FWD_COUNT, m_fwd);
`endif
        $display("cyc %-14s pa=%b pb=%b cmux=%b pc_le=%b ifid_le=%b", tag, FWD_SEL_PA, FWD_SEL_PB,
                 CONTROL_MUX, PC_LE, IF_ID_LE);
        @(posedge clk);
`ifdef HAZARD_STATS_EN
        if (reset || STATS_CLEAR) begin
            m_stall = 0;
            m_fwd   = 0;
        end else begin
            if (st && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if ((ea != 0 || eb != 0) && m_fwd != 32'hFFFF_FFFF) m_fwd = m_fwd + 1;
        end
`endif
        if (reset) pend = 0;
        else if (pend > 0) pend = pend - 1;
        else if (hz && ID_EARLY_USE) pend = 1;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        cycle("idle");

        // Forwarding priority on port A.
        EX_DEST = 5; MEM_DEST = 5; WB_DEST = 5;
        EX_RF_ENABLE = 1; MEM_RF_ENABLE = 1; WB_RF_ENABLE = 1;
        ID_RS = 5; ID_USES_RS = 1;
        cycle("fwd_ex");
        chk("fwd_ex_direct", 32'(FWD_SEL_PA), 32'd1);
        EX_RF_ENABLE = 0;
        cycle("fwd_mem");
        MEM_RF_ENABLE = 0;
        cycle("fwd_wb");
        ID_RS = 0;
        cycle("fwd_r0");

        // Load-use, normal consumer: one stall, then forward from MEM.
        idle_inputs();
        EX_DEST = 8; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RT = 8; ID_USES_RT = 1;
        cycle("lu_stall");
        EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0; EX_DEST = 0;
        MEM_DEST = 8; MEM_RF_ENABLE = 1; MEM_LOAD_INSTR = 1;
        cycle("lu_mem");
        chk("lu_mem_direct", 32'(FWD_SEL_PB), 32'd2);

        // Load-use, early consumer: two stalls, then forward from WB.
`ifdef HAZARD_STATS_EN
        STATS_CLEAR = 1;
        cycle("clr");
        STATS_CLEAR = 0;
`endif
        idle_inputs();
        EX_DEST = 8; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RS = 8; ID_USES_RS = 1; ID_EARLY_USE = 1;
        cycle("eu_s1");
        EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0; EX_DEST = 0;
        MEM_DEST = 8; MEM_RF_ENABLE = 1; MEM_LOAD_INSTR = 1;
        cycle("eu_s2");
        MEM_DEST = 0; MEM_RF_ENABLE = 0; MEM_LOAD_INSTR = 0;
        WB_DEST = 8; WB_RF_ENABLE = 1;
        cycle("eu_wb");
        chk("eu_wb_direct", 32'(FWD_SEL_PA), 32'd3);
`ifdef HAZARD_STATS_EN
        chk("eu_stall_cnt2", STALL_COUNT, 32'd2);
        STATS_CLEAR = 1;
        cycle("clr2");
        STATS_CLEAR = 0;
        chk("clr_stall0", STALL_COUNT, 32'd0);
`endif

        // Reset landing in BR_WAIT cancels any further stall.
        idle_inputs();
        EX_DEST = 9; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RS = 9; ID_USES_RS = 1; ID_EARLY_USE = 1;
        cycle("rb_s1");
        EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0; EX_DEST = 0;
        MEM_DEST = 9; MEM_RF_ENABLE = 1; MEM_LOAD_INSTR = 1;
        reset = 1;
        cycle("rb_bw_rst");
        reset = 0;
        idle_inputs();
        cycle("rb_after");
        chk("rb_after_pc", 32'(PC_LE), 32'd1);

`ifdef HAZARD_STATS_EN
        // Saturation: preload counters just below the ceiling and keep stalling.
        idle_inputs();
        force dut.stall_count_q = 32'hFFFF_FFFE;
        force dut.fwd_count_q   = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        release dut.fwd_count_q;
        m_stall = 32'hFFFF_FFFE;
        m_fwd   = 32'hFFFF_FFFE;
        EX_DEST = 4; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RT = 4; ID_USES_RT = 1;
        for (int i = 0; i < 4; i++) cycle("sat");
        chk("sat_stall", STALL_COUNT, 32'hFFFF_FFFF);
        chk("sat_fwd", FWD_COUNT, 32'hFFFF_FFFF);
`endif

        // Random traffic with a narrow address range to provoke frequent matches.
        for (int i = 0; i < 1500; i++) begin
            ID_RS = 5'($urandom_range(0, 3));
            ID_RT = 5'($urandom_range(0, 3));
            ID_USES_RS = 1'($urandom);
            ID_USES_RT = 1'($urandom);
            ID_EARLY_USE = 1'($urandom);
            EX_DEST = 5'($urandom_range(0, 3));
            MEM_DEST = 5'($urandom_range(0, 3));
            WB_DEST = 5'($urandom_range(0, 3));
            EX_RF_ENABLE = 1'($urandom);
            MEM_RF_ENABLE = 1'($urandom);
            WB_RF_ENABLE = 1'($urandom);
            EX_LOAD_INSTR = 1'($urandom);
            MEM_LOAD_INSTR = 1'($urandom);
            reset = ($urandom_range(0, 49) == 0);
`ifdef HAZARD_STATS_EN
            STATS_CLEAR = ($urandom_range(0, 29) == 0);
`endif
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
